// File: rtl/seg7_scan_driver.sv
// Three-digit BCD scan driver for a 4-anode common-anode 7-segment display.
// New digits are committed only at scan-frame boundaries; leading zeros may be blanked.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] cent,
  input  logic [3:0] dec,
  input  logic [3:0] uni,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       update_done
);

  localparam int            PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic          r_pend_valid;
  logic [3:0]    r_pend_cent, r_pend_dec, r_pend_uni;
  logic [3:0]    r_disp_cent, r_disp_dec, r_disp_uni;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_done;

  logic          w_tick;
  logic          w_frame;
  logic [3:0]    w_digit;
  logic          w_blank;
  logic [3:0]    w_an;

  function automatic logic [6:0] f_encode(input logic [3:0] d);
    case (d)
      4'd0:    f_encode = 7'b1000000;
      4'd1:    f_encode = 7'b1111001;
      4'd2:    f_encode = 7'b0100100;
      4'd3:    f_encode = 7'b0110000;
      4'd4:    f_encode = 7'b0011001;
      4'd5:    f_encode = 7'b0010010;
      4'd6:    f_encode = 7'b0000010;
      4'd7:    f_encode = 7'b1111000;
      4'd8:    f_encode = 7'b0000000;
      4'd9:    f_encode = 7'b0010000;
      default: f_encode = 7'b0111111;
    endcase
  endfunction

  assign w_tick  = (r_presc == LAST);
  assign w_frame = w_tick && (r_idx == 2'd2);

  // Blanked slots keep their anode low so every digit gets the same duty cycle.
  always_comb begin
    w_digit = r_disp_uni;
    w_blank = 1'b0;
    w_an    = 4'b1110;
    case (r_idx)
      2'd1: begin
        w_digit = r_disp_dec;
        w_blank = BLANK_LZ && (r_disp_cent == 4'd0) && (r_disp_dec == 4'd0);
        w_an    = 4'b1101;
      end
      2'd2: begin
        w_digit = r_disp_cent;
        w_blank = BLANK_LZ && (r_disp_cent == 4'd0);
        w_an    = 4'b1011;
      end
      default: begin
        w_digit = r_disp_uni;
        w_blank = 1'b0;
        w_an    = 4'b1110;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc      <= '0;
      r_idx        <= 2'd0;
      r_pend_valid <= 1'b0;
      r_pend_cent  <= 4'd0;
      r_pend_dec   <= 4'd0;
      r_pend_uni   <= 4'd0;
      r_disp_cent  <= 4'd0;
      r_disp_dec   <= 4'd0;
      r_disp_uni   <= 4'd0;
      r_an         <= 4'b1111;
      r_seg        <= 7'b1111111;
      r_done       <= 1'b0;
    end else begin
      r_an   <= w_an;
      r_seg  <= w_blank ? 7'b1111111 : f_encode(w_digit);
      r_done <= 1'b0;

      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      // A load on the boundary itself bypasses the pending stage and wins.
      if (w_frame && load) begin
        r_disp_cent  <= cent;
        r_disp_dec   <= dec;
        r_disp_uni   <= uni;
        r_pend_valid <= 1'b0;
        r_done       <= 1'b1;
      end else if (w_frame && r_pend_valid) begin
        r_disp_cent  <= r_pend_cent;
        r_disp_dec   <= r_pend_dec;
        r_disp_uni   <= r_pend_uni;
        r_pend_valid <= 1'b0;
        r_done       <= 1'b1;
      end else if (load) begin
        r_pend_cent  <= cent;
        r_pend_dec   <= dec;
        r_pend_uni   <= uni;
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = 1'b1;
  assign update_done = r_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (blanking on/off) checked every cycle
// against a cycle-count based reference model of the scan and commit rules.
module tb_seg7_scan_driver;

  localparam int DIV = 4;
  localparam int FR  = 3 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [3:0] cent = 4'd0, dec = 4'd0, uni = 4'd0;
  logic [3:0] an_lz, an_nl;
  logic [6:0] seg_lz, seg_nl;
  logic       dp_lz, dp_nl, done_lz, done_nl;

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) u_lz (
    .clk(clk), .reset(reset), .load(load), .cent(cent), .dec(dec), .uni(uni),
    .an(an_lz), .seg(seg_lz), .dp(dp_lz), .update_done(done_lz));

  seg7_scan_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) u_nl (
    .clk(clk), .reset(reset), .load(load), .cent(cent), .dec(dec), .uni(uni),
    .an(an_nl), .seg(seg_nl), .dp(dp_nl), .update_done(done_nl));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: e = rising edges since reset release; digits index 0=units,1=tens,2=hundreds.
  logic [6:0] SEG_TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int         e;
  logic [3:0] md [3];
  logic [3:0] mp [3];
  bit         mpv;
  logic [3:0] x_an;
  logic [6:0] x_seg_lz, x_seg_nl;
  logic       x_done;

  function automatic logic [6:0] enc(input logic [3:0] d);
    return (d <= 4'd9) ? SEG_TAB[d] : 7'b0111111;
  endfunction

  function automatic logic [6:0] slot_seg(input int slot, input bit blz);
    if (slot == 0) return enc(md[0]);
    if (slot == 1) return (blz && md[2] == 0 && md[1] == 0) ? 7'b1111111 : enc(md[1]);
    return (blz && md[2] == 0) ? 7'b1111111 : enc(md[2]);
  endfunction

  task automatic model_reset();
    e = 0;
    mpv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      md[i] = 4'd0;
      mp[i] = 4'd0;
    end
  endtask

  task automatic model_edge(input bit l, input logic [3:0] c, input logic [3:0] d,
                            input logic [3:0] u);
    int  slot;
    bit  frame;
    slot     = (e / DIV) % 3;
    x_an     = ~(4'b0001 << slot);
    x_seg_lz = slot_seg(slot, 1'b1);
    x_seg_nl = slot_seg(slot, 1'b0);
    frame    = ((e + 1) % FR) == 0;
    x_done   = 1'b0;
    if (frame && l) begin
      md[0] = u; md[1] = d; md[2] = c; mpv = 1'b0; x_done = 1'b1;
    end else if (frame && mpv) begin
      md = mp; mpv = 1'b0; x_done = 1'b1;
    end else if (l) begin
      mp[0] = u; mp[1] = d; mp[2] = c; mpv = 1'b1;
    end
    e++;
  endtask

  task automatic check_outs();
    chk("an_lz",     32'(an_lz),   32'(x_an));
    chk("seg_lz",    32'(seg_lz),  32'(x_seg_lz));
    chk("done_lz",   32'(done_lz), 32'(x_done));
    chk("an_nolz",   32'(an_nl),   32'(x_an));
    chk("seg_nolz",  32'(seg_nl),  32'(x_seg_nl));
    chk("done_nolz", 32'(done_nl), 32'(x_done));
    chk("dp",        32'({dp_lz, dp_nl}), 32'(2'b11));
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_an"},   32'({an_lz, an_nl}),     32'(8'hFF));
    chk({tag, "_seg"},  32'({seg_lz, seg_nl}),   32'(14'h3FFF));
    chk({tag, "_dp"},   32'({dp_lz, dp_nl}),     32'(2'b11));
    chk({tag, "_done"}, 32'({done_lz, done_nl}), 32'(2'b00));
  endtask

  // Called at a falling edge: drive, take one rising edge, then check at the next falling edge.
  task automatic cyc(input bit l, input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
    load = l; cent = c; dec = d; uni = u;
    @(posedge clk);
    model_edge(l, c, d, u);
    @(negedge clk);
    load = 1'b0;
    check_outs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic idle_until(input int phase);
    while ((e % FR) != phase) cyc(1'b0, 4'd0, 4'd0, 4'd0);
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b0;
    #2 check_reset_outs("rst_async");
    @(negedge clk);
    @(negedge clk);
    check_reset_outs("rst_held");
    reset = 1'b1;

    idle(FR + 2);

    cyc(1'b1, 4'd1, 4'd2, 4'd3);
    idle(2 * FR);

    cyc(1'b1, 4'd0, 4'd0, 4'd7);
    idle(2 * FR);

    cyc(1'b1, 4'd0, 4'hA, 4'd5);
    idle(2 * FR);

    idle_until(1);
    cyc(1'b1, 4'd1, 4'd1, 4'd1);
    idle(2);
    cyc(1'b1, 4'd4, 4'd5, 4'd6);
    idle(2 * FR);

    idle_until(FR - 1);
    cyc(1'b1, 4'd8, 4'd0, 4'd2);
    idle(FR);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    idle_until(3);
    cyc(1'b1, 4'd9, 4'd9, 4'd9);
    idle(1);
    #2 reset = 1'b0;
    #1 check_reset_outs("rst_mid");
    model_reset();
    @(negedge clk);
    check_reset_outs("rst_mid_held");
    reset = 1'b1;
    idle(3 * FR);

    for (int i = 0; i < 100; i++) begin
      cyc($urandom_range(0, 3) == 0, 4'($urandom_range(0, 9)),
          4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
    end
    idle(2 * FR);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
